// File: rtl/megamapper_pkg.sv
// Shared types and constants for the Nabu MegaMapper I/O guard.
package megamapper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    HIT  = 2'd2,
    PUSH = 2'd3
  } io_guard_state_t;

  typedef struct packed {
    logic       dir;
    logic [7:0] port;
    logic [7:0] data;
  } io_evt_t;

  localparam logic [7:0] IO_FILL_DEFAULT = 8'hFF;

endpackage

// File: rtl/io_evt_fifo.sv
// Synchronous capture FIFO for guarded I/O events, with a registered head
// and a sticky overflow flag.
module io_evt_fifo
  import megamapper_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  io_evt_t din,
  input  logic    pop,
  output io_evt_t head,
  output logic    valid,
  output logic    full,
  output logic    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  io_evt_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  io_evt_t       head_reg;
  logic          overflow_reg;
  logic          empty, do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_pop) rd_ptr_next = rd_ptr_reg + 1'b1;
    if (do_push && !do_pop) count_next = count_reg + 1'b1;
    else if (!do_push && do_pop) count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      // Head forwards the incoming entry when it lands in the next head slot.
      if (count_next == '0) head_reg <= '0;
      else if (do_push && (wr_ptr_reg == rd_ptr_next)) head_reg <= din;
      else head_reg <= mem[rd_ptr_next];
      if (push && !do_push) overflow_reg <= 1'b1;
      else if (do_pop && overflow_reg && (count_reg == CW'(1))) overflow_reg <= 1'b0;
    end
  end

  assign head     = head_reg;
  assign valid    = !empty;
  assign overflow = overflow_reg;

endmodule

// File: rtl/io_guard.sv
// Guest I/O access guard: protection bitmap, access FSM and event capture FIFO.
// Optional IO_GUARD_RDVAL_EN: rd_fill becomes programmable via cfg_wr to port 0xFF.
module io_guard
  import megamapper_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       m1_n,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic       virtual_enabled,
  input  logic       trap_state,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_port,
  input  logic       cfg_prot,
  input  logic       pop,
  output logic       io_violation,
  output logic       io_block,
  output logic       rd_fill_oe,
  output logic [7:0] rd_fill,
  output logic       evt_valid,
  output logic       evt_dir,
  output logic [7:0] evt_port,
  output logic [7:0] evt_data,
  output logic       overflow
);

  io_guard_state_t state_reg, state_next;
  logic [255:0]    bitmap_reg;
  logic            dir_reg, dir_next;
  logic [7:0]      port_reg, port_next;
  logic [7:0]      data_reg, data_next;
  logic [1:0]      viol_cnt_reg, viol_cnt_next;
  logic            valid_io, guard_active, detect, push, bitmap_we, fifo_full;
  io_evt_t         push_evt, head;

  assign valid_io     = !iorq_n && m1_n && (!rd_n || !wr_n);
  assign guard_active = virtual_enabled && !trap_state;
  // Gated by reset so the block drops as soon as a reset aborts the access.
  assign detect       = (state_reg == IDLE) && valid_io && guard_active &&
                        bitmap_reg[addr] && !reset;

`ifdef IO_GUARD_RDVAL_EN
  logic [7:0] rd_fill_reg;

  assign bitmap_we = cfg_wr && (cfg_port != 8'hFF);

  always_ff @(posedge clk) begin
    if (reset) rd_fill_reg <= IO_FILL_DEFAULT;
    else if (cfg_wr && (cfg_port == 8'hFF)) rd_fill_reg <= {8{cfg_prot}};
  end

  assign rd_fill = rd_fill_reg;
`else
  assign bitmap_we = cfg_wr;
  assign rd_fill   = IO_FILL_DEFAULT;
`endif

  always_ff @(posedge clk) begin
    if (reset) bitmap_reg <= '1;
    else if (bitmap_we) bitmap_reg[cfg_port] <= cfg_prot;
  end

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    port_next  = port_reg;
    data_next  = data_reg;
    push       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (detect) begin
          state_next = HIT;
          dir_next   = !wr_n;
          port_next  = addr;
          data_next  = data_in;
        end else if (valid_io) begin
          state_next = PASS;
        end
      end
      PASS: if (iorq_n) state_next = IDLE;
      HIT: begin
        // Write data keeps tracking the bus until the strobe ends.
        if (iorq_n) state_next = PUSH;
        else if (dir_reg) data_next = data_in;
      end
      PUSH: begin
        push       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    viol_cnt_next = viol_cnt_reg;
    if (detect) viol_cnt_next = 2'd2;
    else if (viol_cnt_reg != 2'd0) viol_cnt_next = viol_cnt_reg - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      dir_reg      <= 1'b0;
      port_reg     <= 8'h00;
      data_reg     <= 8'h00;
      viol_cnt_reg <= 2'd0;
    end else begin
      state_reg    <= state_next;
      dir_reg      <= dir_next;
      port_reg     <= port_next;
      data_reg     <= data_next;
      viol_cnt_reg <= viol_cnt_next;
    end
  end

  always_comb begin
    push_evt      = '0;
    push_evt.dir  = dir_reg;
    push_evt.port = port_reg;
    push_evt.data = dir_reg ? data_reg : 8'h00;
  end

  io_evt_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .din     (push_evt),
    .pop     (pop),
    .head    (head),
    .valid   (evt_valid),
    .full    (fifo_full),
    .overflow(overflow)
  );

  assign io_violation = (viol_cnt_reg != 2'd0);
  assign io_block     = detect || (state_reg == HIT);
  assign rd_fill_oe   = io_block && (detect ? wr_n : !dir_reg);
  assign evt_dir      = head.dir;
  assign evt_port     = head.port;
  assign evt_data     = head.data;

endmodule

// File: tb/tb_io_guard.sv
// Directed self-checking bench for io_guard (DEPTH = 4).
module tb_io_guard;

  logic       clk = 1'b0;
  logic       reset, iorq_n, rd_n, wr_n, m1_n;
  logic [7:0] addr, data_in, cfg_port;
  logic       virtual_enabled, trap_state, cfg_wr, cfg_prot, pop;
  logic       io_violation, io_block, rd_fill_oe, evt_valid, evt_dir, overflow;
  logic [7:0] rd_fill, evt_port, evt_data;

  int checks = 0;
  int errors = 0;

  logic       ob_blk0, ob_oe0, ob_viol1, ob_blk1, ob_viol2, ob_blk2, ob_blkr, ob_viol3, ob_blk3;
  logic [7:0] ob_fill0;

  io_guard #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .addr(addr), .data_in(data_in), .virtual_enabled(virtual_enabled),
    .trap_state(trap_state), .cfg_wr(cfg_wr), .cfg_port(cfg_port), .cfg_prot(cfg_prot),
    .pop(pop), .io_violation(io_violation), .io_block(io_block), .rd_fill_oe(rd_fill_oe),
    .rd_fill(rd_fill), .evt_valid(evt_valid), .evt_dir(evt_dir), .evt_port(evt_port),
    .evt_data(evt_data), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full bus cycle: detection, one extra strobe cycle, strobe release, PUSH, IDLE.
  task automatic bus_cycle(input logic wr, input logic inta, input logic [7:0] port,
                           input logic [7:0] data, input logic pop_at_push);
    addr    = port;
    iorq_n  = 1'b0;
    m1_n    = !inta;
    rd_n    = wr || inta;
    wr_n    = !(wr && !inta);
    data_in = ~data;
    #1;
    ob_blk0 = io_block; ob_oe0 = rd_fill_oe; ob_fill0 = rd_fill;
    tick();
    ob_viol1 = io_violation; ob_blk1 = io_block;
    data_in = data;
    tick();
    ob_viol2 = io_violation; ob_blk2 = io_block;
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; data_in = 8'h00;
    #1;
    ob_blkr = io_block;
    tick();
    ob_viol3 = io_violation; ob_blk3 = io_block;
    pop = pop_at_push;
    tick();
    pop = 1'b0;
    $display("txn wr=%b inta=%b port=%h data=%h blk=%b%b%b%b viol=%b%b%b evt_valid=%b ovf=%b",
             wr, inta, port, data, ob_blk0, ob_blk1, ob_blk2, ob_blk3,
             ob_viol1, ob_viol2, ob_viol3, evt_valid, overflow);
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    $display("txn pop evt_valid=%b head=%b/%h/%h ovf=%b", evt_valid, evt_dir, evt_port, evt_data, overflow);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    checks++; if (io_block !== 1'b0) begin errors++; $display("FAIL reset_block: got %b expected 0", io_block); end
    checks++; if (io_violation !== 1'b0) begin errors++; $display("FAIL reset_viol: got %b expected 0", io_violation); end
    checks++; if (rd_fill_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", rd_fill_oe); end
    checks++; if (rd_fill !== 8'hFF) begin errors++; $display("FAIL reset_fill: got %h expected ff", rd_fill); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
    checks++; if ({evt_dir, evt_port, evt_data} !== 17'h0) begin errors++; $display("FAIL reset_evt: got %h expected 0", {evt_dir, evt_port, evt_data}); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_write();
    bus_cycle(1'b1, 1'b0, 8'h40, 8'h5A, 1'b0);
    checks++; if (ob_blk0 !== 1'b1) begin errors++; $display("FAIL wr_block_c0: got %b expected 1", ob_blk0); end
    checks++; if (ob_oe0 !== 1'b0) begin errors++; $display("FAIL wr_oe_c0: got %b expected 0", ob_oe0); end
    checks++; if ({ob_viol1, ob_viol2, ob_viol3} !== 3'b110) begin errors++; $display("FAIL wr_viol_pulse: got %b expected 110", {ob_viol1, ob_viol2, ob_viol3}); end
    checks++; if ({ob_blk1, ob_blk2, ob_blkr, ob_blk3} !== 4'b1110) begin errors++; $display("FAIL wr_block_hold: got %b expected 1110", {ob_blk1, ob_blk2, ob_blkr, ob_blk3}); end
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL wr_valid: got %b expected 1", evt_valid); end
    checks++; if ({evt_dir, evt_port, evt_data} !== {1'b1, 8'h40, 8'h5A}) begin errors++; $display("FAIL wr_entry: got %b/%h/%h expected 1/40/5a", evt_dir, evt_port, evt_data); end
    do_pop();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL wr_drain: got %b expected 0", evt_valid); end
  endtask

  task automatic test_cfg_pass();
    cfg_wr = 1'b1; cfg_port = 8'h41; cfg_prot = 1'b0;
    tick();
    cfg_wr = 1'b0;
    bus_cycle(1'b0, 1'b0, 8'h41, 8'h00, 1'b0);
    checks++; if ({ob_blk0, ob_blk1, ob_oe0} !== 3'b000) begin errors++; $display("FAIL cfg_unprot_block: got %b expected 000", {ob_blk0, ob_blk1, ob_oe0}); end
    checks++; if ({ob_viol1, ob_viol2, evt_valid} !== 3'b000) begin errors++; $display("FAIL cfg_unprot_evt: got %b expected 000", {ob_viol1, ob_viol2, evt_valid}); end
    trap_state = 1'b1;
    bus_cycle(1'b1, 1'b0, 8'h40, 8'h33, 1'b0);
    trap_state = 1'b0;
    checks++; if ({ob_blk0, ob_viol1, evt_valid} !== 3'b000) begin errors++; $display("FAIL trap_pass: got %b expected 000", {ob_blk0, ob_viol1, evt_valid}); end
    // Bitmap write to the port being accessed in the same cycle uses the old bit.
    cfg_wr = 1'b1; cfg_port = 8'h42; cfg_prot = 1'b0;
    addr = 8'h42; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    checks++; if (io_block !== 1'b1) begin errors++; $display("FAIL cfg_same_cycle: got %b expected 1", io_block); end
    tick();
    cfg_wr = 1'b0; iorq_n = 1'b1; rd_n = 1'b1;
    repeat (3) tick();
    checks++; if ({evt_valid, evt_port} !== {1'b1, 8'h42}) begin errors++; $display("FAIL cfg_same_cycle_evt: got %b/%h expected 1/42", evt_valid, evt_port); end
    do_pop();
    bus_cycle(1'b0, 1'b0, 8'h42, 8'h00, 1'b0);
    checks++; if ({ob_blk0, evt_valid} !== 2'b00) begin errors++; $display("FAIL cfg_after_write: got %b expected 00", {ob_blk0, evt_valid}); end
  endtask

  task automatic test_read();
    bus_cycle(1'b0, 1'b0, 8'h80, 8'h77, 1'b0);
    checks++; if ({ob_blk0, ob_oe0} !== 2'b11) begin errors++; $display("FAIL rd_block_oe: got %b expected 11", {ob_blk0, ob_oe0}); end
    checks++; if (ob_fill0 !== 8'hFF) begin errors++; $display("FAIL rd_fill: got %h expected ff", ob_fill0); end
    checks++; if ({ob_viol1, ob_viol2, ob_viol3} !== 3'b110) begin errors++; $display("FAIL rd_viol: got %b expected 110", {ob_viol1, ob_viol2, ob_viol3}); end
    checks++; if ({evt_valid, evt_dir, evt_port, evt_data} !== {1'b1, 1'b0, 8'h80, 8'h00}) begin errors++; $display("FAIL rd_entry: got %b/%b/%h/%h expected 1/0/80/00", evt_valid, evt_dir, evt_port, evt_data); end
    do_pop();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) bus_cycle(1'b1, 1'b0, 8'h10 + 8'(i), 8'hA0 + 8'(i), 1'b0);
    checks++; if (ob_blk0 !== 1'b1) begin errors++; $display("FAIL ovf_still_blocks: got %b expected 1", ob_blk0); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({evt_valid, evt_port, evt_data} !== {1'b1, 8'h10 + 8'(i), 8'hA0 + 8'(i)}) begin
        errors++; $display("FAIL ovf_entry%0d: got %b/%h/%h expected 1/%h/%h", i, evt_valid, evt_port, evt_data, 8'h10 + 8'(i), 8'hA0 + 8'(i));
      end
      do_pop();
      if (i == 2) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
      end
    end
    checks++; if ({evt_valid, overflow} !== 2'b00) begin errors++; $display("FAIL ovf_clear: got %b expected 00", {evt_valid, overflow}); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) bus_cycle(1'b1, 1'b0, 8'h20 + 8'(i), 8'hB0 + 8'(i), 1'b0);
    bus_cycle(1'b1, 1'b0, 8'h24, 8'hB4, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_drop: got %b expected 0", overflow); end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if ({evt_valid, evt_port, evt_data} !== {1'b1, 8'h20 + 8'(i), 8'hB0 + 8'(i)}) begin
        errors++; $display("FAIL b2b_entry%0d: got %b/%h/%h expected 1/%h/%h", i, evt_valid, evt_port, evt_data, 8'h20 + 8'(i), 8'hB0 + 8'(i));
      end
      do_pop();
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", evt_valid); end
    do_pop();
    checks++; if ({evt_valid, overflow} !== 2'b00) begin errors++; $display("FAIL pop_empty: got %b expected 00", {evt_valid, overflow}); end
  endtask

  task automatic test_inta_and_reset_hit();
    bus_cycle(1'b0, 1'b1, 8'h40, 8'h00, 1'b0);
    checks++; if ({ob_blk0, ob_blk1, ob_viol1, evt_valid} !== 4'b0000) begin errors++; $display("FAIL inta_ignored: got %b expected 0000", {ob_blk0, ob_blk1, ob_viol1, evt_valid}); end
    addr = 8'h40; data_in = 8'h99; iorq_n = 1'b0; wr_n = 1'b0;
    tick();
    checks++; if (io_block !== 1'b1) begin errors++; $display("FAIL rst_hit_pre: got %b expected 1", io_block); end
    reset = 1'b1;
    tick();
    checks++; if (io_block !== 1'b0) begin errors++; $display("FAIL rst_hit_block: got %b expected 0", io_block); end
    reset = 1'b0; iorq_n = 1'b1; wr_n = 1'b1;
    repeat (3) tick();
    checks++; if ({evt_valid, io_violation, overflow} !== 3'b000) begin errors++; $display("FAIL rst_hit_fifo: got %b expected 000", {evt_valid, io_violation, overflow}); end
    $display("txn reset during HIT evt_valid=%b", evt_valid);
  endtask

`ifdef IO_GUARD_RDVAL_EN
  task automatic test_rdval();
    cfg_wr = 1'b1; cfg_port = 8'hFF; cfg_prot = 1'b0;
    tick();
    cfg_wr = 1'b0;
    bus_cycle(1'b0, 1'b0, 8'h80, 8'h00, 1'b0);
    checks++; if ({ob_oe0, ob_fill0} !== {1'b1, 8'h00}) begin errors++; $display("FAIL rdval_fill: got %b/%h expected 1/00", ob_oe0, ob_fill0); end
    do_pop();
    bus_cycle(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0);
    checks++; if (ob_blk0 !== 1'b1) begin errors++; $display("FAIL rdval_ff_prot: got %b expected 1", ob_blk0); end
    do_pop();
  endtask
`endif

  initial begin
    reset = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    addr = 8'h00; data_in = 8'h00; virtual_enabled = 1'b1; trap_state = 1'b0;
    cfg_wr = 1'b0; cfg_port = 8'h00; cfg_prot = 1'b0; pop = 1'b0;
    test_reset();
    test_write();
    test_cfg_pass();
    test_read();
    test_overflow();
    test_back_to_back();
    test_inta_and_reset_hit();
`ifdef IO_GUARD_RDVAL_EN
    test_rdval();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
